// File: rtl/spiker_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spiker_reader: snapshots the input-spike registers on start and streams
// them to the spiker core as CHUNK-bit valid/ready beats.   Rev 1.0
// ----------------------------------------------------------------------------
module spiker_reader #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784,
  parameter int N_REG_IN = 25,
  parameter int CHUNK    = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      test_mode_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [N_REG_IN*WIDTH-1:0] spikes_i,
  output logic [CHUNK-1:0]          spk_data_o,
  output logic                      spk_valid_o,
  input  logic                      spk_ready_i,
  output logic                      spk_last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int NBEATS = (N_SPIKES + CHUNK - 1) / CHUNK;
  localparam int PAD_W  = NBEATS * CHUNK;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NBEATS - 1);

  generate
    if (N_REG_IN * WIDTH < N_SPIKES) begin : g_bad_params
      $error("spiker_reader: N_REG_IN*WIDTH must cover N_SPIKES");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [N_SPIKES-1:0] r_shadow;
  logic                w_load;
  logic                w_hs;
  logic                w_send;
  logic [PAD_W-1:0]    w_pad;
  logic                w_unused;

  // Test mode and snapshot bits beyond N_SPIKES carry no function here.
  assign w_unused = ^{test_mode_i, spikes_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) begin
        r_shadow <= spikes_i[N_SPIKES-1:0];
      end
    end
  end

  assign w_send = (r_state == S_SEND);
  assign w_hs   = w_send && spk_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // start beats a simultaneous abort: abort only matters while sending
        if (start_i) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (abort_i) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_hs) begin
          if (r_idx == c_last_idx) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Zero-padded view so the partial final beat reads 0 above N_SPIKES.
  always_comb begin
    w_pad                 = '0;
    w_pad[N_SPIKES-1:0]   = r_shadow;
  end

  assign spk_valid_o = w_send;
  assign busy_o      = w_send;
  assign done_o      = (r_state == S_DONE);
  assign spk_last_o  = w_send && (r_idx == c_last_idx);
  assign spk_data_o  = w_send ? w_pad[r_idx*CHUNK +: CHUNK] : '0;

endmodule
`default_nettype wire

// File: tb/tb_spiker_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spiker_reader: directed self-checking bench for spiker_reader.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_spiker_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         ready = 1'b0;
  logic [799:0] spikes = '0;
  logic [31:0]  data;
  logic         valid, last, busy, done;

  logic         start_s = 1'b0;
  logic         ready_s = 1'b0;
  logic [63:0]  spikes_s = {32'hDEADBEEF, 32'h12345678};
  logic [31:0]  data_s;
  logic         valid_s, last_s, busy_s, done_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spiker_reader dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0), .start_i(start),
    .abort_i(abort), .spikes_i(spikes), .spk_data_o(data), .spk_valid_o(valid),
    .spk_ready_i(ready), .spk_last_o(last), .busy_o(busy), .done_o(done)
  );

  spiker_reader #(.WIDTH(32), .N_SPIKES(64), .N_REG_IN(2), .CHUNK(32)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0), .start_i(start_s),
    .abort_i(1'b0), .spikes_i(spikes_s), .spk_data_o(data_s), .spk_valid_o(valid_s),
    .spk_ready_i(ready_s), .spk_last_o(last_s), .busy_o(busy_s), .done_o(done_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_spikes(input logic [31:0] base);
    for (int i = 0; i < 25; i++) spikes[i*32 +: 32] = base | i;
  endtask

  // Beat k of a frame whose word k is base|k; beat 24 keeps only 16 bits.
  function automatic logic [31:0] exp_beat(input int k, input logic [31:0] base);
    logic [31:0] w;
    w = base | k;
    if (k == 24) return {16'h0000, w[15:0]};
    return w;
  endfunction

  initial begin
    int busy_cycles;
    int hs;
    int done_cnt;
    logic got_done;
    logic stalled;
    logic [31:0] prev_data;
    logic prev_last;

    // Reset state
    #2;
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_busy_done_last", {29'b0, busy, done, last}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    set_spikes(32'hA5000000);

    // Frame 1: ready held high
    start = 1'b1; ready = 1'b1;
    chk("f1_valid_pre", {31'b0, valid}, 32'd0);
    tick();
    start = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 25; k++) begin
      chk($sformatf("f1_data%0d", k), data, exp_beat(k, 32'hA5000000));
      chk($sformatf("f1_last%0d", k), {31'b0, last}, {31'b0, k == 24});
      if (busy && valid) busy_cycles++;
      tick();
    end
    chk("f1_busy_cycles", busy_cycles, 32'd25);
    chk("f1_done", {30'b0, done, valid}, 32'd2);
    chk("f1_busy_after", {31'b0, busy}, 32'd0);
    tick();
    chk("f1_done_clear", {31'b0, done}, 32'd0);

    // Frame 2: ready pattern 1,0,0,1
    start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0;
    hs = 0; got_done = 1'b0; stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (done) begin
        got_done = 1'b1;
      end else if (valid) begin
        if (stalled) begin
          chk($sformatf("f2_stall_data%0d", c), data, prev_data);
          chk($sformatf("f2_stall_last%0d", c), {31'b0, last}, {31'b0, prev_last});
        end
        if (ready) begin
          chk($sformatf("f2_data%0d", hs), data, exp_beat(hs, 32'hA5000000));
          chk($sformatf("f2_last%0d", hs), {31'b0, last}, {31'b0, hs == 24});
          hs++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; prev_data = data; prev_last = last;
        end
      end
      tick();
    end
    chk("f2_got_done", {31'b0, got_done}, 32'd1);
    chk("f2_handshakes", hs, 32'd25);

    // Frame 3: spikes changed and start re-pulsed mid-frame
    ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (k == 5) begin
        spikes = '1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      chk($sformatf("f3_data%0d", k), data, exp_beat(k, 32'hA5000000));
      tick();
    end
    start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) done_cnt++;
      if (c > 0) chk($sformatf("f3_idle_valid%0d", c), {31'b0, valid}, 32'd0);
      tick();
    end
    chk("f3_done_count", done_cnt, 32'd1);

    // Frame 4: abort at beat 10
    set_spikes(32'hA5000000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("f4_beat10", data, exp_beat(10, 32'hA5000000));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("f4_abort_state", {28'b0, valid, last, busy, done}, 32'd0);
    tick();
    chk("f4_no_done", {31'b0, done}, 32'd0);
    set_spikes(32'h5A000000);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("f4_restart_valid", {31'b0, valid}, 32'd1);
    chk("f4_restart_data", data, 32'h5A000000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("f4_abort2_valid", {31'b0, valid}, 32'd0);

    // Frame 5: asynchronous reset at beat 7
    set_spikes(32'hA5000000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("f5_beat7", data, exp_beat(7, 32'hA5000000));
    #2 rst_n = 1'b0;
    #1;
    chk("f5_rst_data", data, 32'd0);
    chk("f5_rst_flags", {28'b0, valid, last, busy, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("f5_idle_valid", {31'b0, valid}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f5_restart_data", data, exp_beat(0, 32'hA5000000));
    chk("f5_restart_last", {30'b0, valid, last}, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Small configuration: 2 beats, no masking
    start_s = 1'b1; ready_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("s_beat0", data_s, 32'h12345678);
    chk("s_last0", {30'b0, valid_s, last_s}, 32'd2);
    tick();
    chk("s_beat1", data_s, 32'hDEADBEEF);
    chk("s_last1", {30'b0, valid_s, last_s}, 32'd3);
    tick();
    chk("s_done", {29'b0, done_s, valid_s, busy_s}, 32'd4);
    tick();
    chk("s_done_clear", {31'b0, done_s}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
